// File: rtl/sdpram_cnt_ctrl_if.sv
// Host-side increment, query and response signals of the statistics counter controller.
interface sdpram_cnt_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 64,
    parameter int unsigned INC_WIDTH  = 16
);
    logic                  inc_valid;
    logic                  inc_ready;
    logic [ADDR_WIDTH-1:0] inc_addr;
    logic [INC_WIDTH-1:0]  inc_val;
    logic                  qry_valid;
    logic                  qry_ready;
    logic [ADDR_WIDTH-1:0] qry_addr;
    logic                  qry_clr;
    logic                  rsp_valid;
    logic [CNT_WIDTH-1:0]  rsp_data;

    modport master (
        output inc_valid, inc_addr, inc_val, qry_valid, qry_addr, qry_clr,
        input  inc_ready, qry_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  inc_valid, inc_addr, inc_val, qry_valid, qry_addr, qry_clr,
        output inc_ready, qry_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sdpram_cnt_ctrl.sv
// Read-modify-write controller for a counter table in a simple dual-port RAM,
// with table clear, query/read-clear port and write-history forwarding.
module sdpram_cnt_ctrl #(
    parameter int unsigned CNT_WIDTH  = 64,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned INC_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdpram_cnt_ctrl_if.slave      bus,
    input  logic                  clr_all,
    output logic                  init_done,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [CNT_WIDTH-1:0]  ram_dina,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [CNT_WIDTH-1:0]  ram_doutb
);
    localparam int unsigned SUM_W = CNT_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} state_e;

    typedef struct packed {
        logic                  vld;
        logic                  is_qry;
        logic                  clr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [INC_WIDTH-1:0]  inc;
    } op_t;

    typedef struct packed {
        logic                  vld;
        logic [ADDR_WIDTH-1:0] addr;
        logic [CNT_WIDTH-1:0]  data;
    } hist_t;

    state_e                state_q, state_d;
    logic                  clr_we_q, clr_we_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  init_done_q;
    op_t                   pipe_q [LATENCY];
    op_t                   pipe_d [LATENCY];
    hist_t                 hist_q [LATENCY];
    hist_t                 hist_d [LATENCY];

    op_t                   issue_op;
    op_t                   res_op;
    logic                  run;
    logic                  pipe_busy;
    logic                  fwd_hit;
    logic                  res_we;
    logic [CNT_WIDTH-1:0]  old_val;
    logic [CNT_WIDTH-1:0]  res_data;
    logic [SUM_W-1:0]      sum;

    assign run = (state_q == ST_RUN);

    // Issue: queries win over increments; one op per cycle.
    always_comb begin
        issue_op = '0;
        if (run && bus.qry_valid) begin
            issue_op.vld    = 1'b1;
            issue_op.is_qry = 1'b1;
            issue_op.clr    = bus.qry_clr;
            issue_op.addr   = bus.qry_addr;
        end else if (run && bus.inc_valid) begin
            issue_op.vld  = 1'b1;
            issue_op.addr = bus.inc_addr;
            issue_op.inc  = bus.inc_val;
        end
    end

    // Result stage: the youngest history write to the same address overrides stale RAM data.
    always_comb begin
        res_op  = pipe_q[LATENCY-1];
        old_val = ram_doutb;
        fwd_hit = 1'b0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            if (!fwd_hit && hist_q[i].vld && (hist_q[i].addr == res_op.addr)) begin
                fwd_hit = 1'b1;
                old_val = hist_q[i].data;
            end
        end
        sum      = {1'b0, old_val} + SUM_W'(res_op.inc);
        res_we   = res_op.vld && (!res_op.is_qry || res_op.clr);
        res_data = '0;
        if (res_op.vld && !res_op.is_qry) begin
            res_data = sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
        end
    end

    assign bus.qry_ready = run;
    assign bus.inc_ready = run && !bus.qry_valid;
    assign bus.rsp_valid = res_op.vld && res_op.is_qry;
    assign bus.rsp_data  = (res_op.vld && res_op.is_qry) ? old_val : '0;
    assign ram_addrb     = issue_op.addr;
    assign ram_wea       = clr_we_q || res_we;
    assign ram_addra     = clr_we_q ? clr_addr_q : (res_we ? res_op.addr : '0);
    assign ram_dina      = res_data;
    assign init_done     = init_done_q;

    // Next state: FSM, clear sweep, op pipeline and time-ordered write history.
    always_comb begin
        state_d    = state_q;
        clr_we_d   = clr_we_q;
        clr_addr_d = clr_addr_q;
        pipe_busy  = 1'b0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            pipe_busy = pipe_busy || pipe_q[i].vld;
        end

        pipe_d[0] = issue_op;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        hist_d[0].vld  = res_we;
        hist_d[0].addr = res_op.addr;
        hist_d[0].data = res_data;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            hist_d[i] = hist_q[i-1];
        end

        case (state_q)
            ST_CLEAR: begin
                if (!clr_we_q) begin
                    clr_we_d   = 1'b1;
                    clr_addr_d = '0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    clr_we_d = 1'b0;
                    state_d  = ST_RUN;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr_all) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pipe_busy) state_d = ST_CLEAR;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_we_q    <= 1'b0;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            clr_we_q    <= clr_we_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= (state_d == ST_RUN);
            pipe_q      <= pipe_d;
            hist_q      <= hist_d;
        end
    end
endmodule

// File: tb/tb_sdpram_cnt_ctrl.sv
// Directed bench: 64-bit/256-entry/latency-2 instance plus an 8-bit/16-entry/latency-3
// instance for saturation, each with a read-first RAM model.
module tb_sdpram_cnt_ctrl;
    localparam int unsigned L_A = 2, D_A = 256, AW_A = 8, CW_A = 64, IW_A = 16;
    localparam int unsigned L_B = 3, D_B = 16,  AW_B = 4, CW_B = 8,  IW_B = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic            clr_all_a, init_done_a, ram_wea_a;
    logic [AW_A-1:0] ram_addra_a, ram_addrb_a;
    logic [CW_A-1:0] ram_dina_a, ram_doutb_a;
    logic            clr_all_b, init_done_b, ram_wea_b;
    logic [AW_B-1:0] ram_addra_b, ram_addrb_b;
    logic [CW_B-1:0] ram_dina_b, ram_doutb_b;

    sdpram_cnt_ctrl_if #(.ADDR_WIDTH(AW_A), .CNT_WIDTH(CW_A), .INC_WIDTH(IW_A)) bus_a ();
    sdpram_cnt_ctrl_if #(.ADDR_WIDTH(AW_B), .CNT_WIDTH(CW_B), .INC_WIDTH(IW_B)) bus_b ();

    sdpram_cnt_ctrl #(.CNT_WIDTH(CW_A), .DEPTH(D_A), .LATENCY(L_A), .INC_WIDTH(IW_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .clr_all(clr_all_a), .init_done(init_done_a),
        .ram_wea(ram_wea_a), .ram_addra(ram_addra_a), .ram_dina(ram_dina_a),
        .ram_addrb(ram_addrb_a), .ram_doutb(ram_doutb_a)
    );

    sdpram_cnt_ctrl #(.CNT_WIDTH(CW_B), .DEPTH(D_B), .LATENCY(L_B), .INC_WIDTH(IW_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .clr_all(clr_all_b), .init_done(init_done_b),
        .ram_wea(ram_wea_b), .ram_addra(ram_addra_b), .ram_dina(ram_dina_b),
        .ram_addrb(ram_addrb_b), .ram_doutb(ram_doutb_b)
    );

    // Read-first RAM models with LATENCY-cycle registered read
    logic [CW_A-1:0] mem_a [D_A];
    logic [CW_A-1:0] rd_a  [L_A];
    logic [CW_B-1:0] mem_b [D_B];
    logic [CW_B-1:0] rd_b  [L_B];

    always @(posedge clk) begin
        if (ram_wea_a) mem_a[ram_addra_a] <= ram_dina_a;
        rd_a[0] <= mem_a[ram_addrb_a];
        for (int i = 1; i < int'(L_A); i++) rd_a[i] <= rd_a[i-1];
        if (ram_wea_b) mem_b[ram_addra_b] <= ram_dina_b;
        rd_b[0] <= mem_b[ram_addrb_b];
        for (int i = 1; i < int'(L_B); i++) rd_b[i] <= rd_b[i-1];
    end
    assign ram_doutb_a = rd_a[L_A-1];
    assign ram_doutb_b = rd_b[L_B-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of inputs to instance A; returns at that cycle's falling edge.
    task automatic drive_a(input logic iv, input int ia, input int ival,
                           input logic qv, input int qa, input logic qc, input logic ca);
        @(posedge clk); #1;
        bus_a.inc_valid = iv;
        bus_a.inc_addr  = AW_A'(ia);
        bus_a.inc_val   = IW_A'(ival);
        bus_a.qry_valid = qv;
        bus_a.qry_addr  = AW_A'(qa);
        bus_a.qry_clr   = qc;
        clr_all_a       = ca;
        @(negedge clk);
    endtask

    task automatic drive_b(input logic iv, input int ia, input int ival, input logic qv, input int qa);
        @(posedge clk); #1;
        bus_b.inc_valid = iv;
        bus_b.inc_addr  = AW_B'(ia);
        bus_b.inc_val   = IW_B'(ival);
        bus_b.qry_valid = qv;
        bus_b.qry_addr  = AW_B'(qa);
        bus_b.qry_clr   = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_a();
        drive_a(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [AW_A-1:0] exp_addr;
        @(negedge clk);
        rst_n = 1'b0;
        bus_a.inc_valid = 1'b0; bus_a.qry_valid = 1'b0; bus_a.qry_clr = 1'b0;
        bus_a.inc_addr = '0; bus_a.inc_val = '0; bus_a.qry_addr = '0; clr_all_a = 1'b0;
        bus_b.inc_valid = 1'b0; bus_b.qry_valid = 1'b0; bus_b.qry_clr = 1'b0;
        bus_b.inc_addr = '0; bus_b.inc_val = '0; bus_b.qry_addr = '0; clr_all_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.inc_ready, bus_a.qry_ready, bus_a.rsp_valid, bus_a.rsp_data, init_done_a,
             ram_wea_a, ram_addra_a, ram_dina_a, ram_addrb_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got inc_rdy=%0b qry_rdy=%0b rsp_v=%0b rsp_d=%0h done=%0b wea=%0b addra=%0h dina=%0h addrb=%0h exp all 0",
                     bus_a.inc_ready, bus_a.qry_ready, bus_a.rsp_valid, bus_a.rsp_data, init_done_a,
                     ram_wea_a, ram_addra_a, ram_dina_a, ram_addrb_a);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 257; k++) begin
            @(negedge clk);
            if (k <= 256) begin
                exp_addr = AW_A'(k - 1);
                checks++;
                if (ram_wea_a !== 1'b1 || ram_addra_a !== exp_addr || ram_dina_a !== '0) begin
                    errors++;
                    $display("FAIL clear_write cycle=%0d got wea=%0b addr=%0d data=%0h exp wea=1 addr=%0d data=0",
                             k, ram_wea_a, ram_addra_a, ram_dina_a, exp_addr);
                end
                checks++;
                if ({init_done_a, bus_a.inc_ready, bus_a.qry_ready} !== 3'b000) begin
                    errors++;
                    $display("FAIL clear_not_ready cycle=%0d got done/inc/qry=%b exp 000",
                             k, {init_done_a, bus_a.inc_ready, bus_a.qry_ready});
                end
            end else begin
                checks++;
                if ({init_done_a, ram_wea_a, bus_a.qry_ready, bus_a.inc_ready} !== 4'b1011) begin
                    errors++;
                    $display("FAIL init_done_rise got done/wea/qry/inc=%b exp 1011",
                             {init_done_a, ram_wea_a, bus_a.qry_ready, bus_a.inc_ready});
                end
            end
        end
        checks++;
        if (init_done_b !== 1'b1) begin
            errors++;
            $display("FAIL init_done_b got=%0b exp=1", init_done_b);
        end
    endtask

    task automatic test_back_to_back();
        drive_a(1'b1, 5, 1, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (bus_a.inc_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%0b exp=1", bus_a.inc_ready); end
        drive_a(1'b1, 5, 2, 1'b0, 0, 1'b0, 1'b0);
        drive_a(1'b1, 5, 3, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (ram_wea_a !== 1'b1 || ram_addra_a !== 8'd5 || ram_dina_a !== 64'd1) begin
            errors++; $display("FAIL b2b_wr1 got wea=%0b addr=%0d data=%0d exp 1/5/1", ram_wea_a, ram_addra_a, ram_dina_a);
        end
        drive_a(1'b0, 0, 0, 1'b1, 5, 1'b0, 1'b0);
        checks++;
        if (ram_wea_a !== 1'b1 || ram_dina_a !== 64'd3) begin
            errors++; $display("FAIL b2b_wr2 got wea=%0b data=%0d exp 1/3", ram_wea_a, ram_dina_a);
        end
        idle_a();
        checks++;
        if (ram_wea_a !== 1'b1 || ram_dina_a !== 64'd6 || bus_a.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_wr3 got wea=%0b data=%0d rsp_v=%0b exp 1/6/0", ram_wea_a, ram_dina_a, bus_a.rsp_valid);
        end
        idle_a();
        checks++;
        if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== 64'd6 || ram_wea_a !== 1'b0) begin
            errors++; $display("FAIL b2b_rsp got v=%0b data=%0d wea=%0b exp 1/6/0", bus_a.rsp_valid, bus_a.rsp_data, ram_wea_a);
        end
    endtask

    task automatic test_read_clear();
        drive_a(1'b1, 3, 7, 1'b0, 0, 1'b0, 1'b0);
        drive_a(1'b0, 0, 0, 1'b1, 3, 1'b1, 1'b0);
        drive_a(1'b1, 3, 4, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (ram_wea_a !== 1'b1 || ram_addra_a !== 8'd3 || ram_dina_a !== 64'd7) begin
            errors++; $display("FAIL rc_inc_wr got wea=%0b addr=%0d data=%0d exp 1/3/7", ram_wea_a, ram_addra_a, ram_dina_a);
        end
        drive_a(1'b0, 0, 0, 1'b1, 3, 1'b0, 1'b0);
        checks++;
        if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== 64'd7 || ram_wea_a !== 1'b1 || ram_dina_a !== '0) begin
            errors++; $display("FAIL rc_rsp1 got v=%0b data=%0d wea=%0b dina=%0d exp 1/7/1/0",
                               bus_a.rsp_valid, bus_a.rsp_data, ram_wea_a, ram_dina_a);
        end
        idle_a();
        checks++;
        if (bus_a.rsp_valid !== 1'b0 || ram_wea_a !== 1'b1 || ram_dina_a !== 64'd4) begin
            errors++; $display("FAIL rc_inc2_wr got rsp_v=%0b wea=%0b data=%0d exp 0/1/4", bus_a.rsp_valid, ram_wea_a, ram_dina_a);
        end
        idle_a();
        checks++;
        if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== 64'd4) begin
            errors++; $display("FAIL rc_rsp2 got v=%0b data=%0d exp 1/4", bus_a.rsp_valid, bus_a.rsp_data);
        end
    endtask

    task automatic test_arbitration();
        drive_a(1'b1, 20, 5, 1'b0, 0, 1'b0, 1'b0);
        drive_a(1'b1, 20, 9, 1'b1, 20, 1'b0, 1'b0);
        checks++;
        if (bus_a.inc_ready !== 1'b0 || bus_a.qry_ready !== 1'b1 || ram_addrb_a !== 8'd20) begin
            errors++; $display("FAIL arb_qry_first got inc_rdy=%0b qry_rdy=%0b addrb=%0d exp 0/1/20",
                               bus_a.inc_ready, bus_a.qry_ready, ram_addrb_a);
        end
        drive_a(1'b1, 20, 9, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (bus_a.inc_ready !== 1'b1 || ram_wea_a !== 1'b1 || ram_dina_a !== 64'd5) begin
            errors++; $display("FAIL arb_inc_next got inc_rdy=%0b wea=%0b data=%0d exp 1/1/5", bus_a.inc_ready, ram_wea_a, ram_dina_a);
        end
        idle_a();
        checks++;
        if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== 64'd5 || ram_wea_a !== 1'b0) begin
            errors++; $display("FAIL arb_rsp got v=%0b data=%0d wea=%0b exp 1/5/0", bus_a.rsp_valid, bus_a.rsp_data, ram_wea_a);
        end
        idle_a();
        checks++;
        if (ram_wea_a !== 1'b1 || ram_addra_a !== 8'd20 || ram_dina_a !== 64'd14) begin
            errors++; $display("FAIL arb_inc_wr got wea=%0b addr=%0d data=%0d exp 1/20/14", ram_wea_a, ram_addra_a, ram_dina_a);
        end
    endtask

    task automatic test_clr_all();
        int  n_we;
        bit  seen;
        int  qaddr [4];
        qaddr = '{7, 3, 5, 20};
        drive_a(1'b1, 7, 11, 1'b0, 0, 1'b0, 1'b0);
        drive_a(1'b0, 0, 0, 1'b1, 3, 1'b0, 1'b1);
        checks++;
        if (bus_a.qry_ready !== 1'b1) begin errors++; $display("FAIL ca_accept got qry_rdy=%0b exp 1", bus_a.qry_ready); end
        drive_a(1'b1, 7, 1, 1'b1, 3, 1'b0, 1'b0);
        checks++;
        if ({bus_a.qry_ready, bus_a.inc_ready, init_done_a} !== 3'b000 || ram_dina_a !== 64'd11) begin
            errors++; $display("FAIL ca_drain got qry/inc/done=%b dina=%0d exp 000/11",
                               {bus_a.qry_ready, bus_a.inc_ready, init_done_a}, ram_dina_a);
        end
        idle_a();
        checks++;
        if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== 64'd4) begin
            errors++; $display("FAIL ca_pending_rsp got v=%0b data=%0d exp 1/4", bus_a.rsp_valid, bus_a.rsp_data);
        end
        idle_a();
        checks++;
        if (bus_a.rsp_valid !== 1'b0) begin errors++; $display("FAIL ca_no_rsp got v=%0b exp 0", bus_a.rsp_valid); end
        n_we = 0;
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            idle_a();
            if (init_done_a === 1'b1) seen = 1'b1;
            else if (ram_wea_a === 1'b1 && ram_dina_a === '0 && ram_addra_a === AW_A'(n_we)) n_we++;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL ca_reinit got init_done=0 after 600 cycles exp 1"); end
        checks++;
        if (n_we != 256) begin errors++; $display("FAIL ca_clear_writes got=%0d exp=256", n_we); end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive_a(1'b0, 0, 0, 1'b1, qaddr[i], 1'b0, 1'b0);
            else idle_a();
            if (i >= 2) begin
                checks++;
                if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== '0) begin
                    errors++; $display("FAIL ca_zero addr=%0d got v=%0b data=%0h exp 1/0",
                                       qaddr[i-2], bus_a.rsp_valid, bus_a.rsp_data);
                end
            end
        end
    endtask

    task automatic test_saturation();
        drive_b(1'b1, 9, 200, 1'b0, 0);
        checks++;
        if (bus_b.inc_ready !== 1'b1) begin errors++; $display("FAIL sat_ready got=%0b exp=1", bus_b.inc_ready); end
        drive_b(1'b1, 9, 100, 1'b0, 0);
        drive_b(1'b0, 0, 0, 1'b1, 9);
        drive_b(1'b0, 0, 0, 1'b0, 0);
        checks++;
        if (ram_wea_b !== 1'b1 || ram_addra_b !== 4'd9 || ram_dina_b !== 8'd200) begin
            errors++; $display("FAIL sat_wr1 got wea=%0b addr=%0d data=%0d exp 1/9/200", ram_wea_b, ram_addra_b, ram_dina_b);
        end
        drive_b(1'b0, 0, 0, 1'b0, 0);
        checks++;
        if (ram_wea_b !== 1'b1 || ram_dina_b !== 8'd255) begin
            errors++; $display("FAIL sat_wr2 got wea=%0b data=%0d exp 1/255", ram_wea_b, ram_dina_b);
        end
        drive_b(1'b0, 0, 0, 1'b0, 0);
        checks++;
        if (bus_b.rsp_valid !== 1'b1 || bus_b.rsp_data !== 8'd255) begin
            errors++; $display("FAIL sat_rsp got v=%0b data=%0d exp 1/255", bus_b.rsp_valid, bus_b.rsp_data);
        end
    endtask

    // Query in flight when reset hits: no response, clear restarts from address 0.
    task automatic test_reset_midop();
        drive_a(1'b0, 0, 0, 1'b1, 20, 1'b0, 1'b0);
        idle_a();
        test_reset();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_back_to_back();
        test_read_clear();
        test_arbitration();
        test_saturation();
        test_clr_all();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
